// File: rtl/skew_feeder.sv
// skew_feeder: west-edge activation skew buffer for a ROWS x ROWS systolic MAC array.
// Accepts one ROWS x DEPTH tile per valid/ready transfer into a pending buffer, moves it
// into an active per-row shift register, and streams one element per row per cycle with
// row r delayed r cycles so the array sees a diagonal wavefront. Back-to-back tiles
// stream without bubbles because the next tile launches on the same edge the current
// tile's final element leaves.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   tile offered
//   in_ready   pending buffer free (transfer on in_valid && in_ready)
//   in_data    tile, element (r,k) at bits [(r*DEPTH+k)*DATA_W +: DATA_W]
//   row_data   row r value at bits [r*DATA_W +: DATA_W]
//   row_valid  bit r high when row r carries a real element
//   tile_done  one-cycle pulse with element (ROWS-1, DEPTH-1) of each tile
//   busy       pending tile held or any element in flight
module skew_feeder #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ROWS   = 4,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*DEPTH*DATA_W-1:0]  in_data,
   output logic [ROWS*DATA_W-1:0]        row_data,
   output logic [ROWS-1:0]               row_valid,
   output logic                          tile_done,
   output logic                          busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   // Tile layout matches in_data bit packing: [row][element][bit].
   typedef logic [ROWS-1:0][DEPTH-1:0][DATA_W-1:0] tile_t;

   tile_t             pend_q, pend_d;
   logic              pend_v_q, pend_v_d;
   tile_t             act_q, act_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              launch;

   logic [ROWS-1:0][DATA_W-1:0] head_data;
   logic                        head_v;
   logic                        head_last;

   logic [ROWS-1:0]   stage_any;
   logic              last_out;

   // Pending/active buffer next-state: accept, shift, launch.
   always_comb begin
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      act_d    = act_q;
      cnt_d    = cnt_q;
      accept   = in_valid && !pend_v_q;
      // Launch when active is empty or its final element leaves on this edge.
      launch   = pend_v_q && (cnt_q <= CNT_W'(1));

      if (accept) begin
         pend_d   = tile_t'(in_data);
         pend_v_d = 1'b1;
      end

      if (cnt_q != '0) begin
         for (int r = 0; r < int'(ROWS); r++) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
               act_d[r][k] = act_q[r][k+1];
            end
            act_d[r][DEPTH-1] = '0;
         end
         cnt_d = cnt_q - CNT_W'(1);
      end

      // Launch overrides the final shift; accept cannot coincide since in_ready is low.
      if (launch) begin
         act_d    = pend_q;
         cnt_d    = CNT_W'(DEPTH);
         pend_v_d = 1'b0;
      end
   end

   // Buffer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         act_q    <= '0;
         cnt_q    <= '0;
      end else begin
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         act_q    <= act_d;
         cnt_q    <= cnt_d;
      end
   end

   // Row heads; masked to zero whenever no element is active.
   always_comb begin
      head_v    = (cnt_q != '0);
      head_last = (cnt_q == CNT_W'(1));
      for (int r = 0; r < int'(ROWS); r++) begin
         head_data[r] = head_v ? act_q[r][0] : '0;
      end
   end

   // Per-row skew: row r head passes through r register stages.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      if (r == 0) begin : g_head
         assign row_data[0 +: DATA_W] = head_data[0];
         assign row_valid[0]          = head_v;
         assign stage_any[0]          = 1'b0;
      end else begin : g_dly
         logic [r-1:0][DATA_W-1:0] sd_q;
         logic [r-1:0]             sv_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               sd_q <= '0;
               sv_q <= '0;
            end else begin
               sd_q[0] <= head_data[r];
               sv_q[0] <= head_v;
               for (int j = 1; j < r; j++) begin
                  sd_q[j] <= sd_q[j-1];
                  sv_q[j] <= sv_q[j-1];
               end
            end
         end

         assign row_data[r*DATA_W +: DATA_W] = sd_q[r-1];
         assign row_valid[r]                 = sv_q[r-1];
         assign stage_any[r]                 = |sv_q;
      end
   end

   // Last-element flag only matters on the bottom row, so only that chain is kept.
   if (ROWS == 1) begin : g_last_head
      assign last_out = head_last;
   end else begin : g_last_dly
      logic [ROWS-2:0] sl_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            sl_q <= '0;
         end else begin
            sl_q[0] <= head_last;
            for (int j = 1; j < int'(ROWS) - 1; j++) begin
               sl_q[j] <= sl_q[j-1];
            end
         end
      end

      assign last_out = sl_q[ROWS-2];
   end

   assign in_ready  = !pend_v_q;
   assign tile_done = last_out;
   assign busy      = pend_v_q | head_v | (|stage_any);

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: table-driven check of skew_feeder (defaults) plus a hand-written
// sequence on an 8-row, 2-deep, 16-bit instance.
module tb_skew_feeder;

   localparam int unsigned NR = 4;
   localparam int unsigned ND = 4;
   localparam int unsigned DW = 8;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [31:0]  row_data;
   logic [3:0]   row_valid;
   logic         tile_done;
   logic         busy;

   logic         rst2;
   logic         v2;
   logic         rdy2;
   logic [255:0] d2;
   logic [127:0] rd2;
   logic [7:0]   rv2;
   logic         done2;
   logic         busy2;

   skew_feeder dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .row_data  (row_data),
      .row_valid (row_valid),
      .tile_done (tile_done),
      .busy      (busy)
   );

   skew_feeder #(.DATA_W(16), .ROWS(8), .DEPTH(2)) dut2 (
      .clk       (clk),
      .reset     (rst2),
      .in_valid  (v2),
      .in_ready  (rdy2),
      .in_data   (d2),
      .row_data  (rd2),
      .row_valid (rv2),
      .tile_done (done2),
      .busy      (busy2)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         rst;
      logic         v;
      logic [127:0] d;
      logic [31:0]  e_rd;
      logic [3:0]   e_rv;
      logic         e_done;
      logic         e_busy;
      logic         e_ready;
      int           ph;
      int           cyc;
   } vec_t;

   vec_t vq[$];

   // Per-phase scratch: stimulus per edge and hand-stated accept/launch edges per tile.
   logic         s_v [64];
   logic         s_r [64];
   logic [127:0] s_d [64];
   int           ta [4];
   int           tl [4];
   logic [127:0] td [4];
   int           nt;
   int           rst_edge;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_tile(input logic [7:0] base);
      logic [127:0] t;
      t = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            t[(r*4+k)*8 +: 8] = base + 8'(16*r + k);
      return t;
   endfunction

   task automatic clr_stim();
      for (int i = 0; i < 64; i++) begin
         s_v[i] = 1'b0;
         s_r[i] = 1'b0;
         s_d[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      nt       = 0;
      rst_edge = 1000;
   endtask

   task automatic add_tile(input int a, input int l, input logic [127:0] d);
      ta[nt] = a;
      tl[nt] = l;
      td[nt] = d;
      nt++;
   endtask

   // Expected outputs after edge t: row r shows element t-r-L of the tile launched at L.
   task automatic build(input int n, input int ph);
      vec_t         x;
      logic         pend;
      logic [127:0] tmp;
      int           k;
      for (int t = 0; t < n; t++) begin
         x.rst    = s_r[t];
         x.v      = s_v[t];
         x.d      = s_d[t];
         x.e_rd   = '0;
         x.e_rv   = '0;
         x.e_done = 1'b0;
         pend     = 1'b0;
         if (t < rst_edge) begin
            for (int i = 0; i < nt; i++) begin
               if (t >= ta[i] && t < tl[i]) pend = 1'b1;
               if (t == tl[i] + int'(NR) - 1 + int'(ND) - 1) x.e_done = 1'b1;
               for (int r = 0; r < int'(NR); r++) begin
                  k = t - r - tl[i];
                  if (k >= 0 && k < int'(ND)) begin
                     tmp = td[i];
                     x.e_rv[r] = 1'b1;
                     x.e_rd[r*8 +: 8] = tmp[(r*4+k)*8 +: 8];
                  end
               end
            end
         end
         x.e_ready = !pend;
         x.e_busy  = pend | (|x.e_rv);
         x.ph      = ph;
         x.cyc     = t;
         vq.push_back(x);
      end
   endtask

   initial begin
      logic [127:0] t0, t1, t2, t3, t4, t5, g;
      logic [3:0]   e_rv_loc;
      logic [7:0]   e_rv2;

      t0 = mk_tile(8'h00);
      t1 = mk_tile(8'h40);
      t2 = mk_tile(8'h80);
      t3 = mk_tile(8'hC0);
      t4 = mk_tile(8'h20);
      t5 = mk_tile(8'h90);
      g  = mk_tile(8'h33);

      // Phase 1: single tile accepted at edge 0, launched at edge 1.
      clr_stim();
      s_v[0] = 1'b1; s_d[0] = t0;
      add_tile(0, 1, t0);
      build(10, 1);

      // Phase 2: three tiles with in_valid held; data advances after each acceptance.
      clr_stim();
      for (int i = 0; i <= 6; i++) s_v[i] = 1'b1;
      s_d[0] = t1;
      for (int i = 1; i <= 2; i++) s_d[i] = t2;
      for (int i = 3; i <= 6; i++) s_d[i] = t3;
      add_tile(0, 1, t1);
      add_tile(2, 5, t2);
      add_tile(6, 9, t3);
      build(18, 2);

      // Phase 3: backpressure; garbage offered while the second tile is pending.
      clr_stim();
      for (int i = 0; i <= 5; i++) s_v[i] = 1'b1;
      s_d[0] = t4;
      s_d[1] = t5;
      s_d[2] = t5;
      for (int i = 3; i <= 5; i++) s_d[i] = g;
      add_tile(0, 1, t4);
      add_tile(2, 5, t5);
      build(14, 3);

      // Phase 4: reset while row 2 is mid-tile, with a transfer offered on the reset edge.
      clr_stim();
      s_v[0] = 1'b1; s_d[0] = t1;
      s_v[5] = 1'b1; s_d[5] = g; s_r[5] = 1'b1;
      add_tile(0, 1, t1);
      rst_edge = 5;
      build(6, 4);

      // Phase 5: fresh tile after the reset streams as in phase 1.
      clr_stim();
      s_v[0] = 1'b1; s_d[0] = t0;
      add_tile(0, 1, t0);
      build(10, 5);

      // Phase 6: idle with random in_data.
      clr_stim();
      build(20, 6);

      rst      = 1'b1;
      rst2     = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      v2       = 1'b0;
      d2       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 128'(in_ready), 128'(1));
      chk("reset_rd", 128'(row_data), 128'(0));
      chk("reset_rv", 128'(row_valid), 128'(0));
      chk("reset_done", 128'(tile_done), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset2_busy", 128'(busy2), 128'(0));
      rst2 = 1'b0;

      foreach (vq[i]) begin
         rst      = vq[i].rst;
         in_valid = vq[i].v;
         in_data  = vq[i].d;
         @(posedge clk);
         #1;
         chk($sformatf("p%0d_c%0d_row_data", vq[i].ph, vq[i].cyc), 128'(row_data), 128'(vq[i].e_rd));
         chk($sformatf("p%0d_c%0d_row_valid", vq[i].ph, vq[i].cyc), 128'(row_valid), 128'(vq[i].e_rv));
         chk($sformatf("p%0d_c%0d_tile_done", vq[i].ph, vq[i].cyc), 128'(tile_done), 128'(vq[i].e_done));
         chk($sformatf("p%0d_c%0d_busy", vq[i].ph, vq[i].cyc), 128'(busy), 128'(vq[i].e_busy));
         chk($sformatf("p%0d_c%0d_in_ready", vq[i].ph, vq[i].cyc), 128'(in_ready), 128'(vq[i].e_ready));
      end
      rst      = 1'b0;
      in_valid = 1'b0;

      // Wide instance: 8 rows, depth 2, element (r,k) = 0x100*r + k.
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 2; k++)
            d2[(r*2+k)*16 +: 16] = 16'(256*r + k);
      v2 = 1'b1;
      @(posedge clk);
      #1;
      v2 = 1'b0;
      chk("w_c0_ready", 128'(rdy2), 128'(0));
      for (int t = 1; t <= 11; t++) begin
         @(posedge clk);
         #1;
         e_rv2 = '0;
         for (int r = 0; r < 8; r++)
            if (t - 1 - r >= 0 && t - 1 - r < 2) e_rv2[r] = 1'b1;
         chk($sformatf("w_c%0d_rv", t), 128'(rv2), 128'(e_rv2));
         chk($sformatf("w_c%0d_done", t), 128'(done2), 128'(t == 9));
         chk($sformatf("w_c%0d_busy", t), 128'(busy2), 128'(t <= 9));
         if (t == 1) chk("w_c1_row0", 128'(rd2[15:0]), 128'(16'h0000));
         if (t == 2) chk("w_c2_row0", 128'(rd2[15:0]), 128'(16'h0001));
         if (t == 3) chk("w_c3_row1", 128'(rd2[31:16]), 128'(16'h0101));
         if (t == 8) chk("w_c8_row7", 128'(rd2[127:112]), 128'(16'h0700));
         if (t == 9) chk("w_c9_row7", 128'(rd2[127:112]), 128'(16'h0701));
         if (t == 10) chk("w_c10_rd", rd2, 128'(0));
      end

      e_rv_loc = row_valid;
      chk("final_idle_rv", 128'(e_rv_loc), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Parameterised, handshaked activation skew buffer for the west edge of a ROWS x ROWS systolic MAC array.
- Accepts one tile of ROWS x DEPTH activations per valid/ready transfer.
- Streams each row out one element per cycle. Row r is delayed r cycles relative to row 0, which produces the diagonal wavefront the array needs.
- A one-tile pending buffer lets consecutive tiles stream with no bubble cycles.

Parameters:
DATA_W, 8, bits per activation element
ROWS, 4, number of array rows fed (≥1)
DEPTH, 4, elements per row per tile (≥2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  tile offered
in_ready  output  1  pending buffer free; transfer on in_valid && in_ready at a rising edge
in_data  input  ROWS*DEPTH*DATA_W  tile; element (r,k) at bits [(r*DEPTH+k)*DATA_W +: DATA_W]
row_data  output  ROWS*DATA_W  row r value at bits [r*DATA_W +: DATA_W]
row_valid  output  ROWS  bit r high when row_data row r carries a real element
tile_done  output  1  one-cycle pulse with the last element (ROWS-1, DEPTH-1) of each tile
busy  output  1  pending tile held or any element in flight

Behaviour:
- Reset, applied synchronously at any time including mid-stream:
  - clears pending buffer, active buffer, all delay stages and counters.
  - After reset: in_ready=1, row_data=0, row_valid=0, tile_done=0, busy=0.
  - A transfer coinciding with reset is dropped.
- Pending buffer: one tile plus pend_v flag.
  - in_ready = !pend_v, registered with no combinational path from in_valid.
  - Accept sets pend_v.
  - Launch clears pend_v.
  - Accept and launch never coincide, because in_ready=0 whenever pend_v=1.
- Active buffer:
  - Per row, a DEPTH-entry shift register plus a shared remaining-count cnt (0..DEPTH).
  - The row head is element k = DEPTH - cnt.
  - Each edge with cnt>0: shift all rows by one, cnt--.
- Launch:
  - Condition: pend_v && cnt<=1, i.e. active is empty or its final element leaves this edge.
  - Action: copy pending into active, set cnt=DEPTH, clear pend_v.
  - Launch on the same edge as a final shift gives a seamless back-to-back stream.
- Skew:
  - Row r head (data, valid, last flag) passes through r register stages; row 0 has 0 stages, row ROWS-1 has ROWS-1 stages.
  - Unused stages carry data=0, valid=0.
  - row_data/row_valid come straight from stage outputs; idle rows output 0.
- Timing, for a tile accepted at edge E with the feeder idle:
  - launch at edge E+1.
  - Row r element k is visible in the cycle after edge E+1+r+k.
- Throughput: one tile per DEPTH cycles when in_valid is held. The next tile must be accepted by edge E+DEPTH to avoid a gap.
- tile_done: asserted in the same cycle that row ROWS-1 presents element DEPTH-1 with row_valid[ROWS-1]=1.
- busy = pend_v | (cnt!=0) | OR of all delay-stage valids.
- Arithmetic: no arithmetic on data; data passes unchanged. cnt width is clog2(DEPTH+1).
- ROWS=1: no delay stages; row 0 only.

Test Plan:
1. Defaults, single tile with (r,k)=16*r+k accepted at edge 0:
   - row 0 emits 0,1,2,3 after edges 1..4; row 3 emits 48..51 after edges 4..7.
   - row_valid shows the diagonal; tile_done pulses with 51; busy falls the following cycle.
2. Defaults, three tiles with in_valid held high:
   - each row_valid bit stays high for 12 contiguous cycles with no gaps.
   - in_ready toggles per launch; tile_done pulses 3 times, 4 cycles apart.
3. Backpressure: second tile offered while pend_v=1:
   - in_ready=0 and in_data changes are ignored until launch.
   - Tile contents are unchanged at the outputs.
4. Reset asserted for 1 cycle while row 2 is mid-tile:
   - next cycle all outputs are 0 and in_ready=1.
   - A new tile afterwards streams exactly as in test 1.
5. DATA_W=16, ROWS=8, DEPTH=2, tile (r,k)=0x100*r+k:
   - row 7 emits 0x700, 0x701 after edges 8 and 9.
   - tile_done coincides with 0x701.
6. Idle with in_valid=0 for 20 cycles: row_data=0, row_valid=0, busy=0 throughout.
